intr_controller: RTL and testbench
==================================

# intr_controller

Interrupt source side of the CPU interrupt interface. It collects up to `N_IRQ` peripheral interrupt lines and one non-maskable source, then latches and prioritises pending requests. It drives the CPU's `INT`, `NMI` and `INT_Disable` inputs and consumes the CPU's `INA` acknowledge. It sits between the peripherals and `cpu`, one instance per CPU.

## Interface
- `N_IRQ`, default 8: number of maskable sources (1..32).
- `NMI_HOLD`, default 4: cycles `NMI` stays high per NMI event (>=1).
- `ACK_TIMEOUT`, default 64: cycles to wait for `INA` before retry. Used only with `INTC_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, same as the CPU clock.
- `rst_n` in 1: asynchronous active-low reset.
- `irq_in` in `N_IRQ`: asynchronous peripheral requests. A rising edge requests service.
- `nmi_src` in 1: asynchronous non-maskable request. A rising edge requests service.
- `mask_we` in 1: write strobe for the mask register.
- `mask_wdata` in `N_IRQ`: new mask value. 1 = source enabled.
- `gie_we` in 1: write strobe for the global enable.
- `gie_wdata` in 1: new global interrupt enable value.
- `eoi` in 1: end-of-interrupt pulse from the handler.
- `INA` in 1: interrupt acknowledge from the CPU.
- `INT` out 1: maskable interrupt request to the CPU.
- `NMI` out 1: non-maskable request to the CPU.
- `INT_Disable` out 1: `~gie`, registered.
- `irq_id` out 5: index of the request being presented or serviced.
- `pending` out `N_IRQ`: raw pending bits.
- `busy` out 1: high in REQ or SERVICE.

## Operation
- **Input capture:** each `irq_in` bit and `nmi_src` pass through a 2-flop synchroniser. A rising edge is `s2 & ~s3`.
- **Pending bits:** an edge sets `pending[i]`. Repeat edges while a bit is already pending merge into it.
- **Clearing:** `pending[irq_id]` clears on acceptance of `INA` in state REQ. If a set and a clear of the same bit happen in one cycle, the set wins.
- **Priority:** `eligible = pending & mask`. The lowest index wins.
- **NMI:**
  - An NMI edge loads a counter with `NMI_HOLD`. `NMI` is high while the counter is nonzero.
  - An edge during an active hold reloads the counter.
  - NMI is independent of `mask`, `gie` and the FSM.
- **FSM states:** IDLE, REQ, SERVICE.
  - IDLE -> REQ when `|eligible & gie & ~NMI`. On entry, latch `irq_id` and assert `INT`.
  - REQ -> SERVICE when `INA` is high. On this transition, drop `INT` and clear the pending bit.
  - REQ -> IDLE if `NMI` rises. `INT` drops and the pending bit is kept, so the request re-arbitrates after the NMI.
  - SERVICE -> IDLE on `eoi`.
  - `eoi` in IDLE or REQ is ignored.
- **Register writes:**
  - `mask` and `gie` writes take effect on the next cycle. They do not abort REQ.
  - If the latched source becomes masked while in REQ, `INT` stays high until `INA` or timeout.
- **Reset:** async; all registers clear. `mask` resets to all-ones.

## Timing
- **Reset values:**
  - `INT`=0, `NMI`=0, `INT_Disable`=1 (`gie`=0), `irq_id`=0, `pending`=0, `busy`=0.
  - FSM = IDLE, NMI counter = 0, synchronisers = 0.
- **Maskable latency:** `irq_in` rises before edge k. `pending` is visible after k+2 and `INT` is high after k+3, provided the FSM is in IDLE with `gie`=1.
- **NMI latency:** `nmi_src` rises before edge k. `NMI` is high after k+2 for exactly `NMI_HOLD` cycles.
- **Acknowledge:** `INA` is sampled synchronously and must be high for at least 1 cycle. `INT` is low the cycle after `INA` is sampled.
- **Back-to-back:** after `eoi` is sampled, the next eligible request raises `INT` 2 cycles later (IDLE is visited for 1 cycle).
- **Async reset:** reset mid-REQ drops `INT` immediately, independent of `clk`.

## Configuration
- **`INTC_TIMEOUT_EN` defined:**
  - In REQ, a counter counts cycles. At `ACK_TIMEOUT` cycles without `INA`, the FSM returns to IDLE and drops `INT`.
  - The pending bit is kept and arbitration retries after 1 IDLE cycle.
  - The counter clears on entering REQ.
- **Undefined:** REQ waits indefinitely for `INA` (or for an NMI preemption). No counter logic is present.

## Test plan
- Reset with `gie`=0, then pulse `irq_in[3]`: `pending`=0x08 after 3 clocks, `INT` stays 0, `INT_Disable`=1.
- Set `gie`=1 and raise `irq_in[5]` and `irq_in[2]` on the same edge: `INT`=1 with `irq_id`=2. After `INA`, `pending`=0x20. After `eoi`, `INT`=1 with `irq_id`=5.
- Write `mask`=0xFB, then pulse `irq_in[2]`: `pending[2]`=1 but `INT` stays 0. Write `mask`=0xFF: `INT`=1 the next cycle, `irq_id`=2.
- Pulse `nmi_src` with `NMI_HOLD`=4 while in REQ on `irq_id`=1: `NMI` is high for exactly 4 cycles, `INT` drops, `pending[1]` stays 1. After NMI ends, `INT` re-asserts with `irq_id`=1.
- With `INTC_TIMEOUT_EN` and `ACK_TIMEOUT`=8, hold `INA`=0: `INT` drops after 8 cycles, re-asserts 2 cycles later, and `pending` is unchanged.
- Assert `rst_n`=0 asynchronously mid-REQ: `INT`, `busy` and `pending` are 0 before the next `clk` edge, and `INT_Disable`=1.

Source files
------------

// File: rtl/intr_controller_if.sv
// Signal bundle between intr_controller and its peripherals/CPU.
// slave = the controller, master = whoever drives requests, register writes and INA.
interface intr_controller_if #(
   parameter int unsigned N_IRQ = 8
) ();

   logic [N_IRQ-1:0] irq_in;
   logic             nmi_src;
   logic             mask_we;
   logic [N_IRQ-1:0] mask_wdata;
   logic             gie_we;
   logic             gie_wdata;
   logic             eoi;
   logic             INA;
   logic             INT;
   logic             NMI;
   logic             INT_Disable;
   logic [4:0]       irq_id;
   logic [N_IRQ-1:0] pending;
   logic             busy;

   modport master (
      output irq_in, nmi_src, mask_we, mask_wdata, gie_we, gie_wdata, eoi, INA,
      input  INT, NMI, INT_Disable, irq_id, pending, busy
   );

   modport slave (
      input  irq_in, nmi_src, mask_we, mask_wdata, gie_we, gie_wdata, eoi, INA,
      output INT, NMI, INT_Disable, irq_id, pending, busy
   );

endinterface

// File: rtl/intr_controller.sv
// Edge-latched, lowest-index-first interrupt source for cpu with a stretched NMI output.
// Define INTC_TIMEOUT_EN to withdraw INT and re-arbitrate when INA is missing for ACK_TIMEOUT cycles.
module intr_controller #(
   parameter int unsigned N_IRQ       = 8,
   parameter int unsigned NMI_HOLD    = 4,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   intr_controller_if.slave bus
);

   localparam int unsigned   NW       = $clog2(NMI_HOLD + 1);
   localparam logic [NW-1:0] NMI_LOAD = NW'(NMI_HOLD);
   localparam logic [NW-1:0] NMI_ONE  = NW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   generate
      if (N_IRQ < 1 || N_IRQ > 32 || NMI_HOLD < 1 || ACK_TIMEOUT < 1) begin : g_bad_params
         $error("intr_controller: parameter out of range");
      end
   endgenerate

   logic [N_IRQ-1:0] irq_s1_q, irq_s2_q, irq_s3_q;
   logic             nmi_s1_q, nmi_s2_q, nmi_s3_q;
   logic [N_IRQ-1:0] irq_edge;
   logic             nmi_edge;

   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] eligible, clr_vec;
   logic             gie_q, gie_d;

   logic [NW-1:0]    nmi_cnt_q, nmi_cnt_d;
   logic             nmi_active;

   state_t           state_q, state_d;
   logic [4:0]       irq_id_q, irq_id_d;
   logic [4:0]       win_id;
   logic             ack;

`ifdef INTC_TIMEOUT_EN
   localparam int unsigned   TW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);
   logic [TW-1:0]    to_cnt_q, to_cnt_d;
`endif

   // s2/s3 are both past the metastability stage, so the edge detect is glitch-free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_s1_q <= '0;
         irq_s2_q <= '0;
         irq_s3_q <= '0;
         nmi_s1_q <= 1'b0;
         nmi_s2_q <= 1'b0;
         nmi_s3_q <= 1'b0;
      end else begin
         irq_s1_q <= bus.irq_in;
         irq_s2_q <= irq_s1_q;
         irq_s3_q <= irq_s2_q;
         nmi_s1_q <= bus.nmi_src;
         nmi_s2_q <= nmi_s1_q;
         nmi_s3_q <= nmi_s2_q;
      end
   end

   assign irq_edge   = irq_s2_q & ~irq_s3_q;
   assign nmi_edge   = nmi_s2_q & ~nmi_s3_q;
   assign nmi_active = (nmi_cnt_q != '0);
   assign eligible   = pending_q & mask_q;

   always_comb begin
      mask_d = mask_q;
      gie_d  = gie_q;
      if (bus.mask_we) mask_d = bus.mask_wdata;
      if (bus.gie_we)  gie_d  = bus.gie_wdata;
   end

   always_comb begin
      nmi_cnt_d = nmi_cnt_q;
      if (nmi_edge)
         nmi_cnt_d = NMI_LOAD;
      else if (nmi_active)
         nmi_cnt_d = nmi_cnt_q - NMI_ONE;
   end

   always_comb begin
      win_id = '0;
      for (int unsigned i = N_IRQ; i > 0; i--) begin
         if (eligible[i-1]) win_id = 5'(i - 1);
      end
   end

   always_comb begin
      clr_vec = '0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         clr_vec[i] = ack && (irq_id_q == 5'(i));
      end
   end

   // a fresh edge on the bit being acknowledged must survive the clear
   assign pending_d = (pending_q & ~clr_vec) | irq_edge;

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      ack      = 1'b0;
`ifdef INTC_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            // also hold off on an NMI edge this cycle so INT and NMI never rise together
            if ((|eligible) && gie_q && !nmi_active && !nmi_edge) begin
               state_d  = S_REQ;
               irq_id_d = win_id;
`ifdef INTC_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         S_REQ: begin
            if (bus.INA) begin
               state_d = S_SERVICE;
               ack     = 1'b1;
            end else if (nmi_edge) begin
               state_d = S_IDLE;
            end
`ifdef INTC_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               state_d = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
`endif
         end
         S_SERVICE: begin
            if (bus.eoi) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         irq_id_q  <= '0;
         pending_q <= '0;
         mask_q    <= '1;
         gie_q     <= 1'b0;
         nmi_cnt_q <= '0;
`ifdef INTC_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         irq_id_q  <= irq_id_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         gie_q     <= gie_d;
         nmi_cnt_q <= nmi_cnt_d;
`ifdef INTC_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end
   end

   assign bus.INT         = (state_q == S_REQ);
   assign bus.NMI         = nmi_active;
   assign bus.INT_Disable = ~gie_q;
   assign bus.irq_id      = irq_id_q;
   assign bus.pending     = pending_q;
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: directed scenarios plus a randomized run
// against a flag-level reference model.
module tb_intr_controller;

   localparam int unsigned N    = 8;
   localparam int unsigned HOLD = 4;
   localparam int unsigned TMO  = 8;
`ifdef INTC_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   intr_controller_if #(.N_IRQ(N)) bus ();

   intr_controller #(
      .N_IRQ(N),
      .NMI_HOLD(HOLD),
      .ACK_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [N-1:0] m_pend, m_mask, h1, h2, h3;
   bit           n1, n2, n3;
   bit           m_gie, m_int, m_svc;
   int           m_id, m_nmi, m_req;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.irq_in     = '0;
      bus.nmi_src    = 1'b0;
      bus.mask_we    = 1'b0;
      bus.mask_wdata = '0;
      bus.gie_we     = 1'b0;
      bus.gie_wdata  = 1'b0;
      bus.eoi        = 1'b0;
      bus.INA        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic gie_on();
      bus.gie_we = 1'b1; bus.gie_wdata = 1'b1;
      tick();
      bus.gie_we = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      tests++;
      if ({bus.INT, bus.NMI, bus.INT_Disable, bus.busy} !== 4'b0010) begin
         fails++;
         $display("FAIL reset_flags: INT/NMI/INT_Disable/busy got %b want 0010",
                  {bus.INT, bus.NMI, bus.INT_Disable, bus.busy});
      end
      tests++;
      if (bus.irq_id !== 5'd0) begin
         fails++; $display("FAIL reset_irq_id: got %0d want 0", bus.irq_id);
      end
      tests++;
      if (bus.pending !== 8'h00) begin
         fails++; $display("FAIL reset_pending: got %h want 00", bus.pending);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_gie_off();
      do_reset();
      bus.irq_in[3] = 1'b1;
      tick(); tick();
      tests++;
      if (bus.pending !== 8'h00) begin
         fails++; $display("FAIL gieoff_pend_early: got %h want 00", bus.pending);
      end
      bus.irq_in[3] = 1'b0;
      tick();
      tests++;
      if (bus.pending !== 8'h08) begin
         fails++; $display("FAIL gieoff_pend: got %h want 08", bus.pending);
      end
      repeat (3) tick();
      tests++;
      if ({bus.INT, bus.INT_Disable, bus.busy} !== 3'b010) begin
         fails++;
         $display("FAIL gieoff_int: INT/INT_Disable/busy got %b want 010",
                  {bus.INT, bus.INT_Disable, bus.busy});
      end
   endtask

   task automatic test_priority_b2b();
      do_reset();
      gie_on();
      tests++;
      if (bus.INT_Disable !== 1'b0) begin
         fails++; $display("FAIL prio_intdis: got %b want 0", bus.INT_Disable);
      end
      bus.irq_in = 8'h24;
      repeat (3) tick();
      tests++;
      if (bus.pending !== 8'h24 || bus.INT !== 1'b0) begin
         fails++; $display("FAIL prio_latency: pend %h INT %b want 24/0", bus.pending, bus.INT);
      end
      tick();
      tests++;
      if (bus.INT !== 1'b1 || bus.irq_id !== 5'd2 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL prio_first: INT %b id %0d busy %b want 1/2/1", bus.INT, bus.irq_id, bus.busy);
      end
      bus.INA = 1'b1;
      tick();
      bus.INA = 1'b0;
      tests++;
      if (bus.INT !== 1'b0 || bus.pending !== 8'h20 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL prio_ack: INT %b pend %h busy %b want 0/20/1", bus.INT, bus.pending, bus.busy);
      end
      repeat (2) tick();
      tests++;
      if (bus.INT !== 1'b0 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL prio_service: INT %b busy %b want 0/1", bus.INT, bus.busy);
      end
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      tests++;
      if (bus.INT !== 1'b0 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL b2b_idle: INT %b busy %b want 0/0", bus.INT, bus.busy);
      end
      tick();
      tests++;
      if (bus.INT !== 1'b1 || bus.irq_id !== 5'd5) begin
         fails++; $display("FAIL b2b_next: INT %b id %0d want 1/5", bus.INT, bus.irq_id);
      end
      bus.INA = 1'b1; tick(); bus.INA = 1'b0;
      bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
      bus.irq_in = '0;
   endtask

   task automatic test_mask();
      do_reset();
      gie_on();
      bus.mask_we = 1'b1; bus.mask_wdata = 8'hFB;
      tick();
      bus.mask_we = 1'b0;
      bus.irq_in[2] = 1'b1;
      tick();
      bus.irq_in[2] = 1'b0;
      repeat (5) tick();
      tests++;
      if (bus.pending !== 8'h04 || bus.INT !== 1'b0) begin
         fails++; $display("FAIL mask_block: pend %h INT %b want 04/0", bus.pending, bus.INT);
      end
      bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF;
      tick();
      bus.mask_we = 1'b0;
      tick();
      tests++;
      if (bus.INT !== 1'b1 || bus.irq_id !== 5'd2) begin
         fails++; $display("FAIL mask_unblock: INT %b id %0d want 1/2", bus.INT, bus.irq_id);
      end
      bus.mask_we = 1'b1; bus.mask_wdata = 8'h00;
      tick();
      bus.mask_we = 1'b0;
      repeat (3) tick();
      tests++;
      if (bus.INT !== 1'b1) begin
         fails++; $display("FAIL mask_in_req: INT got %b want 1", bus.INT);
      end
      bus.INA = 1'b1;
      tick();
      bus.INA = 1'b0;
      tests++;
      if (bus.INT !== 1'b0 || bus.pending !== 8'h00) begin
         fails++; $display("FAIL mask_ack: INT %b pend %h want 0/00", bus.INT, bus.pending);
      end
      bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
   endtask

   task automatic test_nmi();
      int nmi_cnt, first_nmi, first_int, id_at;
      logic int_at, pend_at;
      nmi_cnt = 0; first_nmi = -1; first_int = -1; id_at = -1;
      int_at = 1'bx; pend_at = 1'bx;
      do_reset();
      gie_on();
      bus.irq_in[1] = 1'b1;
      repeat (4) tick();
      tests++;
      if (bus.INT !== 1'b1 || bus.irq_id !== 5'd1) begin
         fails++; $display("FAIL nmi_pre: INT %b id %0d want 1/1", bus.INT, bus.irq_id);
      end
      bus.nmi_src = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (i == 0) bus.nmi_src = 1'b0;
         if (bus.NMI === 1'b1) begin
            nmi_cnt++;
            if (first_nmi < 0) begin
               first_nmi = i; int_at = bus.INT; pend_at = bus.pending[1];
            end
         end
         if (first_nmi >= 0 && bus.INT === 1'b1 && first_int < 0) begin
            first_int = i; id_at = int'(bus.irq_id);
         end
      end
      tests++;
      if (first_nmi != 2 || nmi_cnt != int'(HOLD)) begin
         fails++; $display("FAIL nmi_hold: first %0d count %0d want 2/%0d", first_nmi, nmi_cnt, HOLD);
      end
      tests++;
      if (int_at !== 1'b0 || pend_at !== 1'b1) begin
         fails++; $display("FAIL nmi_preempt: INT %b pend1 %b want 0/1", int_at, pend_at);
      end
      tests++;
      if (first_int != 7 || id_at != 1) begin
         fails++; $display("FAIL nmi_rearb: at %0d id %0d want 7/1", first_int, id_at);
      end
      bus.INA = 1'b1; tick(); bus.INA = 1'b0;
      bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
      bus.irq_in = '0;
   endtask

`ifdef INTC_TIMEOUT_EN
   task automatic test_timeout();
      int hi;
      hi = 1;
      do_reset();
      gie_on();
      bus.irq_in[6] = 1'b1;
      repeat (4) tick();
      tests++;
      if (bus.INT !== 1'b1 || bus.irq_id !== 5'd6) begin
         fails++; $display("FAIL tmo_pre: INT %b id %0d want 1/6", bus.INT, bus.irq_id);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.INT !== 1'b1) break;
         hi++;
      end
      tests++;
      if (hi != int'(TMO) || bus.pending !== 8'h40) begin
         fails++; $display("FAIL tmo_drop: high %0d pend %h want %0d/40", hi, bus.pending, TMO);
      end
      tick();
      tests++;
      if (bus.INT !== 1'b1 || bus.irq_id !== 5'd6) begin
         fails++; $display("FAIL tmo_retry: INT %b id %0d want 1/6", bus.INT, bus.irq_id);
      end
      bus.INA = 1'b1; tick(); bus.INA = 1'b0;
      bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
      bus.irq_in = '0;
   endtask
`endif

   task automatic test_async_reset();
      do_reset();
      gie_on();
      bus.irq_in[4] = 1'b1;
      repeat (4) tick();
      tests++;
      if (bus.INT !== 1'b1) begin
         fails++; $display("FAIL arst_pre: INT got %b want 1", bus.INT);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.INT, bus.busy, bus.INT_Disable} !== 3'b001 || bus.pending !== 8'h00) begin
         fails++;
         $display("FAIL arst: INT/busy/INT_Disable %b pend %h want 001/00",
                  {bus.INT, bus.busy, bus.INT_Disable}, bus.pending);
      end
      bus.irq_in = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      m_pend = '0; m_mask = '1; h1 = '0; h2 = '0; h3 = '0;
      n1 = 0; n2 = 0; n3 = 0;
      m_gie = 0; m_int = 0; m_svc = 0;
      m_id = 0; m_nmi = 0; m_req = 0;
   endtask

   // one clock edge of the spec's behaviour, given the inputs sampled at that edge
   task automatic model_step(input logic [N-1:0] irq, input bit nmi, input bit mwe,
                             input logic [N-1:0] mwd, input bit gwe, input bit gwd,
                             input bit ev_eoi, input bit ina);
      logic [N-1:0] rise, elig, clr;
      bit nrise, nmi_on;
      int low;
      rise  = h2 & ~h3;
      nrise = n2 & ~n3;
      h3 = h2; h2 = h1; h1 = irq;
      n3 = n2; n2 = n1; n1 = nmi;
      nmi_on = (m_nmi > 0);
      elig = m_pend & m_mask;
      clr  = '0;
      low  = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) low = i;
      if (m_int) begin
         if (ina) begin
            m_int = 0; m_svc = 1; clr[m_id] = 1'b1;
         end else if (nrise) begin
            m_int = 0;
         end else begin
            m_req++;
            if (TO_ON && m_req == int'(TMO)) m_int = 0;
         end
      end else if (m_svc) begin
         if (ev_eoi) m_svc = 0;
      end else if (low >= 0 && m_gie && !nmi_on && !nrise) begin
         m_int = 1; m_id = low; m_req = 0;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (nrise) m_nmi = int'(HOLD);
      else if (m_nmi > 0) m_nmi--;
      if (mwe) m_mask = mwd;
      if (gwe) m_gie = gwd;
   endtask

   task automatic test_random();
      logic [N-1:0] irq, mwd;
      bit nmi, mwe, gwe, gwd, ev, ina;
      do_reset();
      model_reset();
      irq = '0; nmi = 0;
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
         if ($urandom_range(19) == 0) nmi = ~nmi;
         mwe = ($urandom_range(24) == 0);
         mwd = N'($urandom | $urandom);
         gwe = ($urandom_range(29) == 0);
         gwd = ($urandom_range(3) != 0);
         ev  = ($urandom_range(4) == 0);
         ina = ($urandom_range(3) == 0);
         bus.irq_in = irq; bus.nmi_src = nmi;
         bus.mask_we = mwe; bus.mask_wdata = mwd;
         bus.gie_we = gwe; bus.gie_wdata = gwd;
         bus.eoi = ev; bus.INA = ina;
         @(posedge clk);
         model_step(irq, nmi, mwe, mwd, gwe, gwd, ev, ina);
         #1;
         tests++;
         if (bus.INT !== m_int) begin
            fails++; $display("FAIL rnd_INT c%0d: got %b want %b", c, bus.INT, m_int);
         end
         tests++;
         if (bus.NMI !== (m_nmi > 0)) begin
            fails++; $display("FAIL rnd_NMI c%0d: got %b want %b", c, bus.NMI, (m_nmi > 0));
         end
         tests++;
         if (bus.INT_Disable !== !m_gie) begin
            fails++; $display("FAIL rnd_INT_Disable c%0d: got %b want %b", c, bus.INT_Disable, !m_gie);
         end
         tests++;
         if (bus.irq_id !== 5'(m_id)) begin
            fails++; $display("FAIL rnd_irq_id c%0d: got %0d want %0d", c, bus.irq_id, m_id);
         end
         tests++;
         if (bus.pending !== m_pend) begin
            fails++; $display("FAIL rnd_pending c%0d: got %h want %h", c, bus.pending, m_pend);
         end
         tests++;
         if (bus.busy !== (m_int | m_svc)) begin
            fails++; $display("FAIL rnd_busy c%0d: got %b want %b", c, bus.busy, (m_int | m_svc));
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_gie_off();
      test_priority_b2b();
      test_mask();
      test_nmi();
`ifdef INTC_TIMEOUT_EN
      test_timeout();
`endif
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
